fsm_lect_rtc: RTL

- Read-side counterpart of the RTC initialisation/write sequencer: on request, sweeps the RTC time and timer registers over the multiplexed Intel-style address/data bus and latches each byte into a dedicated output register.
- Generates its own a_d/cs/rd/wr timing and drives the address onto the shared bus through the tri-state buffer enable.
- Feeds the display and edit logic with BCD values.

---
 rtl/fsm_lect_rtc_if.sv | 21 ++
 rtl/fsm_lect_rtc.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fsm_lect_rtc_if.sv
// Multiplexed address/data bus between the RTC read sequencer and the RTC.
// The sequencer is the master; the RTC (or its model) is the slave.
interface fsm_lect_rtc_if;
  logic [7:0] dato_in;
  logic [7:0] dato_out;
  logic       buffer_activo;
  logic       a_d;
  logic       cs;
  logic       rd;
  logic       wr;

  modport master (
    input  dato_in,
    output dato_out, buffer_activo, a_d, cs, rd, wr
  );

  modport slave (
    output dato_in,
    input  dato_out, buffer_activo, a_d, cs, rd, wr
  );
endinterface

// File: rtl/fsm_lect_rtc.sv
// RTC read sequencer: sweeps time and timer registers over the bus.
// FSM_LECT_CMD_TRANSFER_EN adds a leading address-only access to ADDR_CMD.
module fsm_lect_rtc #(
`ifdef FSM_LECT_CMD_TRANSFER_EN
  parameter logic [7:0]  ADDR_CMD  = 8'hF0,
`endif
  parameter int unsigned PULSE_CYC = 8,
  parameter logic [7:0]  ADDR_SEG  = 8'h21,
  parameter logic [7:0]  ADDR_TIM  = 8'h41
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           do_it_lect,
  fsm_lect_rtc_if.master bus,
  output logic [7:0]     seg,
  output logic [7:0]     min,
  output logic [7:0]     hora,
  output logic [7:0]     dia,
  output logic [7:0]     mes,
  output logic [7:0]     anio,
  output logic [7:0]     seg_tim,
  output logic [7:0]     min_tim,
  output logic [7:0]     hora_tim,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(PULSE_CYC);
  localparam logic [CW-1:0] LAST = CW'(PULSE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ASET, S_AWR, S_AHOLD,
    S_DSET, S_DRD, S_DHOLD, S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_idx;
  logic          r_done;
  logic [7:0]    r_regs [0:8];
  logic          w_last;
  logic          w_cmd;
  logic [7:0]    w_addr;
  logic          w_cs, w_ad, w_rd, w_wr, w_buf;

`ifdef FSM_LECT_CMD_TRANSFER_EN
  logic r_cmd;
  assign w_cmd = r_cmd;
`else
  assign w_cmd = 1'b0;
`endif

  assign w_last = (r_cnt == LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (do_it_lect) w_next = S_ASET;
      S_ASET:  if (w_last) w_next = S_AWR;
      S_AWR:   if (w_last) w_next = S_AHOLD;
      S_AHOLD: if (w_last) w_next = w_cmd ? S_GAP : S_DSET;
      S_DSET:  if (w_last) w_next = S_DRD;
      S_DRD:   if (w_last) w_next = S_DHOLD;
      S_DHOLD: if (w_last) w_next = S_GAP;
      S_GAP: begin
        if (w_last)
          w_next = (!w_cmd && r_idx == 4'd8) ? S_IDLE : S_ASET;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cs  = 1'b1;
    w_ad  = 1'b1;
    w_rd  = 1'b1;
    w_wr  = 1'b1;
    w_buf = 1'b0;
    case (r_state)
      S_ASET:  begin w_cs = 1'b0; w_ad = 1'b0; w_buf = 1'b1; end
      S_AWR:   begin
        w_cs = 1'b0; w_ad = 1'b0; w_buf = 1'b1; w_wr = 1'b0;
      end
      S_AHOLD: begin w_cs = 1'b0; w_ad = 1'b0; w_buf = 1'b1; end
      S_DSET:  w_cs = 1'b0;
      S_DRD:   begin w_cs = 1'b0; w_rd = 1'b0; end
      S_DHOLD: w_cs = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    if (r_idx < 4'd6)
      w_addr = ADDR_SEG + {4'd0, r_idx};
    else
      w_addr = ADDR_TIM + {4'd0, r_idx - 4'd6};
`ifdef FSM_LECT_CMD_TRANSFER_EN
    if (r_cmd)
      w_addr = ADDR_CMD;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 4'd0;
      r_done  <= 1'b0;
`ifdef FSM_LECT_CMD_TRANSFER_EN
      r_cmd   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_GAP) && (w_next == S_IDLE);
      if (r_state == S_IDLE || w_last)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
      if (r_state == S_IDLE) begin
        r_idx <= 4'd0;
`ifdef FSM_LECT_CMD_TRANSFER_EN
        r_cmd <= 1'b1;
`endif
      end else if (r_state == S_GAP && w_last) begin
`ifdef FSM_LECT_CMD_TRANSFER_EN
        if (r_cmd)
          r_cmd <= 1'b0;
        else
          r_idx <= r_idx + 4'd1;
`else
        r_idx <= r_idx + 4'd1;
`endif
      end
    end
  end

  // Capture on the final D_RD clock while rd is still low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 9; i++)
        r_regs[i] <= 8'h00;
    end else if (r_state == S_DRD && w_last) begin
      r_regs[r_idx] <= bus.dato_in;
    end
  end

  assign bus.cs            = w_cs;
  assign bus.a_d           = w_ad;
  assign bus.rd            = w_rd;
  assign bus.wr            = w_wr;
  assign bus.buffer_activo = w_buf;
  assign bus.dato_out      = w_buf ? w_addr : 8'h00;

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign seg      = r_regs[0];
  assign min      = r_regs[1];
  assign hora     = r_regs[2];
  assign dia      = r_regs[3];
  assign mes      = r_regs[4];
  assign anio     = r_regs[5];
  assign seg_tim  = r_regs[6];
  assign min_tim  = r_regs[7];
  assign hora_tim = r_regs[8];

endmodule
